// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage SRAM controller: turns one 32-bit load/store into two 16-bit
// SRAM accesses and holds ready low until both halves have completed.
module mem_stage_sram_ctrl #(
   parameter int ACCESS_CYCLES = 2,
   parameter int DATA_BASE     = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  MEM_CMD_MEM,
   input  logic [31:0] ALU_res_MEM,
   input  logic [31:0] src2_val_MEM,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N
);

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              is_store_q;
   logic [17:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       offset;
   logic              cmd_valid;
   logic              phase_last;
   logic              active;
   logic              unused_offset_bits;

   // Byte offset from the data segment base; wraps modulo 2^17 words.
   assign offset             = ALU_res_MEM - 32'(DATA_BASE);
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

   assign cmd_valid  = MEM_CMD_MEM[0] ^ MEM_CMD_MEM[1];
   assign phase_last = (cnt_q == LAST);
   assign active     = (state_q == LO) || (state_q == HI);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid) state_d = LO;
         LO:      if (phase_last) state_d = HI;
         HI:      if (phase_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         is_store_q <= 1'b0;
         addr_q     <= '0;
         read_data  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  cnt_q      <= '0;
                  is_store_q <= MEM_CMD_MEM[1];
                  addr_q     <= {offset[18:2], 1'b0};
               end
            end
            LO, HI: begin
               if (phase_last) begin
                  cnt_q <= '0;
                  if (state_q == LO) addr_q[0] <= 1'b1;
                  // Load halves are captured on the closing edge of each phase.
                  if (!is_store_q) begin
                     if (state_q == LO) read_data[15:0]  <= SRAM_DQ;
                     else               read_data[31:16] <= SRAM_DQ;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && cmd_valid) wdata_q <= src2_val_MEM;
   end

   // WE_N rises on the last cycle of each phase so data/address stay stable past the write.
   assign SRAM_ADDR = addr_q;
   assign SRAM_CE_N = !active;
   assign SRAM_UB_N = !active;
   assign SRAM_LB_N = !active;
   assign SRAM_OE_N = !(active && !is_store_q);
   assign SRAM_WE_N = !(active && is_store_q && !phase_last);
   assign SRAM_DQ   = (active && is_store_q) ?
                      ((state_q == HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

   assign ready = (state_q == DONE) || (state_q == IDLE && !cmd_valid);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: default-timing instance with an SRAM
// model plus an ACCESS_CYCLES=1 instance for the below-base wrap case.
module tb_mem_stage_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          errors = 0;
   int          checks = 0;

   logic [1:0]  cmd1 = 2'b00;
   logic [31:0] alu1 = '0;
   logic [31:0] src1 = '0;
   logic [31:0] rd1;
   logic        ready1;
   wire  [15:0] dq1;
   logic [17:0] addr1;
   logic        ub1, lb1, we1, ce1, oe1;

   logic [1:0]  cmd2 = 2'b00;
   logic [31:0] alu2 = '0;
   logic [31:0] src2 = '0;
   logic [31:0] rd2;
   logic        ready2;
   wire  [15:0] dq2;
   logic [17:0] addr2;
   logic        ub2, lb2, we2, ce2, oe2;

   logic [15:0] mem [0:262143];

   logic [15:0] rec_ready, rec_we, rec_oe, rec_ce;
   logic [17:0] rec_addr [0:15];
   logic [15:0] rec_dq   [0:15];
   logic [31:0] rec_rd   [0:15];

   always #5 clk = ~clk;

   mem_stage_sram_ctrl #(.ACCESS_CYCLES(2), .DATA_BASE(1024)) dut (
      .clk(clk), .rst(rst), .MEM_CMD_MEM(cmd1), .ALU_res_MEM(alu1), .src2_val_MEM(src1),
      .read_data(rd1), .ready(ready1), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
      .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
   );

   mem_stage_sram_ctrl #(.ACCESS_CYCLES(1), .DATA_BASE(1024)) dut_fast (
      .clk(clk), .rst(rst), .MEM_CMD_MEM(cmd2), .ALU_res_MEM(alu2), .src2_val_MEM(src2),
      .read_data(rd2), .ready(ready2), .SRAM_DQ(dq2), .SRAM_ADDR(addr2),
      .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_WE_N(we2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
   );

   // SRAM model for the main instance; the second returns an address-derived pattern.
   assign dq1 = (!ce1 && !oe1) ? mem[addr1] : 16'hzzzz;
   always @(posedge clk) if (!ce1 && !we1) mem[addr1] <= dq1;
   assign dq2 = (!ce2 && !oe2) ? (addr2[15:0] ^ 16'hA5A5) : 16'hzzzz;

   task automatic run_txn(input logic [1:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, output int n_low, output int last_i);
      n_low  = 0;
      last_i = 15;
      cmd1 = cmd; alu1 = addr; src1 = data;
      for (int i = 0; i < 16; i++) begin
         #1;
         rec_ready[i] = ready1; rec_we[i] = we1; rec_oe[i] = oe1; rec_ce[i] = ce1;
         rec_addr[i] = addr1; rec_dq[i] = dq1; rec_rd[i] = rd1;
         if (!ready1) n_low++;
         if (i > 0 && ready1) begin
            last_i = i;
            break;
         end
         @(posedge clk); #1;
         if (i == 0) begin
            cmd1 = 2'b00; alu1 = 32'h0BAD_0000; src1 = 32'h5555_AAAA;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #3;
      checks++;
      if ({ready1, ce1, we1, oe1, ub1, lb1} !== 6'b111111) begin
         errors++; $display("FAIL reset_strobes: got %b expected 111111", {ready1, ce1, we1, oe1, ub1, lb1});
      end
      checks++;
      if (rd1 !== 32'h0 || addr1 !== 18'h0) begin
         errors++; $display("FAIL reset_regs: read_data=%h addr=%h expected 0/0", rd1, addr1);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store;
      int n, last;
      run_txn(2'b10, 32'd1028, 32'hDEAD_BEEF, n, last);
      checks++;
      if (n !== 5 || last !== 5) begin
         errors++; $display("FAIL store_ready_low: got %0d cycles (done at %0d) expected 5 (done at 5)", n, last);
      end
      checks++;
      if (rec_we[5:0] !== 6'b110101) begin
         errors++; $display("FAIL store_we_pattern: got %b expected 110101", rec_we[5:0]);
      end
      checks++;
      if (rec_ce[5:0] !== 6'b100001 || rec_oe[5:0] !== 6'b111111) begin
         errors++; $display("FAIL store_ce_oe: got ce=%b oe=%b expected 100001/111111", rec_ce[5:0], rec_oe[5:0]);
      end
      checks++;
      if (rec_addr[1] !== 18'd2 || rec_addr[3] !== 18'd3 || rec_addr[5] !== 18'd3) begin
         errors++; $display("FAIL store_addr: got %h %h %h expected 2 3 3", rec_addr[1], rec_addr[3], rec_addr[5]);
      end
      checks++;
      if (rec_dq[1] !== 16'hBEEF || rec_dq[2] !== 16'hBEEF || rec_dq[3] !== 16'hDEAD) begin
         errors++; $display("FAIL store_dq: got %h %h %h expected BEEF BEEF DEAD", rec_dq[1], rec_dq[2], rec_dq[3]);
      end
      checks++;
      if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
         errors++; $display("FAIL store_mem: got %h %h expected BEEF DEAD", mem[2], mem[3]);
      end
      checks++;
      if (rec_rd[5] !== 32'h0) begin
         errors++; $display("FAIL store_keeps_read_data: got %h expected 0", rec_rd[5]);
      end
   endtask

   task automatic test_load;
      int n, last;
      run_txn(2'b01, 32'd1028, 32'h0, n, last);
      checks++;
      if (n !== 5 || last !== 5) begin
         errors++; $display("FAIL load_ready_low: got %0d cycles (done at %0d) expected 5 (done at 5)", n, last);
      end
      checks++;
      if (rec_oe[5:0] !== 6'b100001 || rec_we[5:0] !== 6'b111111) begin
         errors++; $display("FAIL load_oe_we: got oe=%b we=%b expected 100001/111111", rec_oe[5:0], rec_we[5:0]);
      end
      checks++;
      if (rec_addr[1] !== 18'd2 || rec_addr[3] !== 18'd3) begin
         errors++; $display("FAIL load_addr: got %h %h expected 2 3", rec_addr[1], rec_addr[3]);
      end
      checks++;
      if (rec_rd[3] !== 32'h0000_BEEF) begin
         errors++; $display("FAIL load_low_half: got %h expected 0000BEEF", rec_rd[3]);
      end
      checks++;
      if (rec_rd[5] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL load_data: got %h expected DEADBEEF", rec_rd[5]);
      end
   endtask

   task automatic test_idle_cmds;
      for (int i = 0; i < 20; i++) begin
         cmd1 = (i < 10) ? 2'b00 : 2'b11;
         alu1 = 32'd1024 + 32'(4 * i);
         #1;
         checks++;
         if (ready1 !== 1'b1) begin
            errors++; $display("FAIL idle_ready: cycle %0d cmd %b got %b expected 1", i, cmd1, ready1);
         end
         checks++;
         if ({ce1, we1, oe1} !== 3'b111) begin
            errors++; $display("FAIL idle_strobes: cycle %0d got %b expected 111", i, {ce1, we1, oe1});
         end
         @(posedge clk); #1;
      end
      cmd1 = 2'b00;
      checks++;
      if (rd1 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL idle_read_data: got %h expected DEADBEEF", rd1);
      end
   endtask

   task automatic test_back_to_back;
      logic [11:0] pat;
      logic [31:0] rd_done;
      pat = '0;
      rd_done = '0;
      cmd1 = 2'b10; alu1 = 32'd1024; src1 = 32'h1234_5678;
      for (int i = 0; i < 12; i++) begin
         #1;
         pat[i] = ready1;
         if (i == 11) rd_done = rd1;
         @(posedge clk); #1;
         if (i == 5) begin
            cmd1 = 2'b01; src1 = 32'h0;
         end
      end
      cmd1 = 2'b00;
      checks++;
      if (pat !== 12'h820) begin
         errors++; $display("FAIL b2b_ready_pattern: got %b expected %b", pat, 12'h820);
      end
      checks++;
      if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin
         errors++; $display("FAIL b2b_mem: got %h %h expected 5678 1234", mem[0], mem[1]);
      end
      checks++;
      if (rd_done !== 32'h1234_5678) begin
         errors++; $display("FAIL b2b_load_data: got %h expected 12345678", rd_done);
      end
   endtask

   task automatic test_reset_mid;
      int n, last;
      cmd1 = 2'b10; alu1 = 32'd1032; src1 = 32'hCAFE_F00D;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (we1 !== 1'b0 || addr1 !== 18'd5) begin
         errors++; $display("FAIL midrst_in_hi: got we=%b addr=%h expected 0/5", we1, addr1);
      end
      cmd1 = 2'b00;
      rst  = 1'b0;
      #1;
      checks++;
      if ({ce1, we1, oe1, ub1, lb1, ready1} !== 6'b111111) begin
         errors++; $display("FAIL midrst_strobes: got %b expected 111111", {ce1, we1, oe1, ub1, lb1, ready1});
      end
      checks++;
      if (rd1 !== 32'h0 || addr1 !== 18'h0) begin
         errors++; $display("FAIL midrst_regs: read_data=%h addr=%h expected 0/0", rd1, addr1);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready1 !== 1'b1 || ce1 !== 1'b1) begin
         errors++; $display("FAIL midrst_idle: got ready=%b ce=%b expected 1/1", ready1, ce1);
      end
      run_txn(2'b01, 32'd1024, 32'h0, n, last);
      checks++;
      if (n !== 5 || rec_rd[last] !== 32'h1234_5678) begin
         errors++; $display("FAIL midrst_reload: got %0d cycles data %h expected 5 12345678", n, rec_rd[last]);
      end
   endtask

   task automatic test_wrap_fast;
      int n;
      logic [17:0] a1, a2;
      logic [31:0] rd_done;
      logic        oe_lo;
      n = 0; a1 = '0; a2 = '0; rd_done = '0; oe_lo = 1'b1;
      cmd2 = 2'b01; alu2 = 32'd1020;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!ready2) n++;
         if (i == 1) begin a1 = addr2; oe_lo = oe2; end
         if (i == 2) a2 = addr2;
         if (i > 0 && ready2) begin
            rd_done = rd2;
            break;
         end
         @(posedge clk); #1;
         if (i == 0) cmd2 = 2'b00;
      end
      checks++;
      if (n !== 3) begin
         errors++; $display("FAIL wrap_ready_low: got %0d expected 3", n);
      end
      checks++;
      if (a1 !== 18'h3FFFE || a2 !== 18'h3FFFF || oe_lo !== 1'b0) begin
         errors++; $display("FAIL wrap_addr: got %h %h oe=%b expected 3FFFE 3FFFF 0", a1, a2, oe_lo);
      end
      checks++;
      if (rd_done !== 32'h5A5A_5A5B) begin
         errors++; $display("FAIL wrap_data: got %h expected 5A5A5A5B", rd_done);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_idle_cmds();
      test_back_to_back();
      test_reset_mid();
      test_wrap_fast();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage SRAM controller that sits directly downstream of the EXE/MEM pipeline register. It consumes the registered memory command, ALU result (byte address) and store data. It performs 32-bit loads and stores over the 16-bit external SRAM as two half-word accesses. It holds `ready` low for the whole transaction so the pipeline freezes until the access completes.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: cycles each half-word access holds address and control on the SRAM pins (≥1).
- `DATA_BASE`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_CMD_MEM`  in  2  command: 00 none, 01 load word, 10 store word, 11 reserved (treated as none).
- `ALU_res_MEM`  in  32  byte address of the access.
- `src2_val_MEM`  in  32  store data.
- `read_data`  out  32  registered load result.
- `ready`  out  1  high when no transaction is pending; drives pipeline `Freeze` = !ready.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_WE_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  active-low SRAM strobes.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - With command 01/10: latch base = (ALU_res_MEM − DATA_BASE)[18:2], latch direction and store data, clear the wait counter, go to LO.
  - With command 00/11: stay in IDLE.
- LO: SRAM_ADDR = {base, 1'b0}. After ACCESS_CYCLES cycles, go to HI.
- HI: SRAM_ADDR = {base, 1'b1}. After ACCESS_CYCLES cycles, go to DONE.
- DONE: lasts one cycle, then go to IDLE unconditionally. A new request is only recognised in IDLE.
- Address arithmetic:
  - 32-bit subtraction, truncated to 17 word bits; addresses below DATA_BASE wrap modulo 2^17 words.
  - Byte offset bits [1:0] are ignored.
- Store:
  - LO drives src2[15:0] on SRAM_DQ.
  - HI drives src2[31:16] on SRAM_DQ.
  - SRAM_WE_N is 0 in LO/HI except the final cycle of each phase, where it returns to 1 while data and address remain stable.
  - SRAM_OE_N = 1.
- Load:
  - SRAM_DQ is high-Z and SRAM_OE_N = 0 in LO/HI.
  - read_data[15:0] is sampled at the last cycle of LO.
  - read_data[31:16] is sampled at the last cycle of HI.
  - read_data keeps its value until the next load overwrites it; stores never change it.
- In LO and HI: SRAM_CE_N = 0 and UB_N = LB_N = 0. In IDLE and DONE: all strobes = 1, SRAM_DQ is high-Z, SRAM_ADDR holds its last value.
- `ready` (combinational):
  - 1 in DONE.
  - 1 in IDLE with no valid command.
  - 0 in IDLE with command 01/10.
  - 0 in LO and HI.
- Inputs are ignored after latching; changes on the inputs during LO/HI have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, read_data = 0, SRAM_ADDR = 0.
  - all strobes = 1, SRAM_DQ high-Z.
  - ready = 1 as long as no valid command is present.
- Transaction latency with request seen in IDLE at cycle 0:
  - ready is low for 1 + 2·ACCESS_CYCLES cycles.
  - DONE occurs at cycle 1 + 2·ACCESS_CYCLES. With default ACCESS_CYCLES = 2 that is cycle 5, with ready low in cycles 0–4.
- read_data is valid from DONE onward. The EXE/MEM register advances at the DONE edge.
- Back-to-back requests: DONE → IDLE takes one cycle, so a following request starts at DONE + 1 and is again held for the full latency. Requests never overlap.
- Reset mid-transaction:
  - WE_N/CE_N/OE_N go to 1 and SRAM_DQ goes high-Z asynchronously.
  - A partially written word is acceptable (the upper half may be stale).
  - read_data returns to 0.
- SRAM_DQ is never driven in the same cycle as SRAM_OE_N = 0.

## Test plan
- Store 0xDEADBEEF to ALU_res 1028 (cmd 10) → SRAM_ADDR 2 written 0xBEEF, then address 3 written 0xDEAD; ready low for exactly 5 cycles; WE_N pulses low one cycle per half.
- Load from 1028 (cmd 01) after the above → read_data = 0xDEADBEEF in DONE; OE_N low 4 cycles; DQ never driven by the controller.
- cmd 00 and cmd 11 for 10 cycles → ready stays 1, CE_N/WE_N/OE_N stay 1, read_data unchanged.
- Store to 1024 immediately followed by a load from 1024 → two separate 5-cycle freezes with one ready-high cycle (DONE) between; the load returns the stored value.
- Assert rst low during HI of a store → strobes go to 1 and DQ high-Z without waiting for clk, read_data = 0; after release the FSM is in IDLE and a new load from 1024 completes normally.
- ACCESS_CYCLES = 1, load from 1020 (below base) → word address wraps to 0x1FFFF, SRAM_ADDR 0x3FFFE then 0x3FFFF; ready low 3 cycles.
